instr_issue_sequencer: RTL and testbench

//  Issuing end of the decoder instruction bus. Buffers microsequencer commands in a small FIFO and drives
//  {id, instr_out, cc_out, instr_en_out} cycle by cycle toward the instruction decoder slices.

---
 rtl/instr_issue_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_instr_issue_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_sequencer.sv
// Issue sequencer: buffers microsequencer commands and drives the decoder instruction bus.
// Optional ISSUE_STATS_EN adds a saturating execute-cycle counter (issue_cnt).
module instr_issue_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int RPT_W      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [2:0]                    cmd_id,
    input  logic [RPT_W-1:0]              cmd_rpt,
    input  logic                          flush,
    output logic [2:0]                    id,
    output logic [4:0]                    instr_out,
    output logic                          cc_out,
    output logic                          instr_en_out,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef ISSUE_STATS_EN
    ,
    output logic [15:0]                   issue_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    localparam logic [1:0] OP_PUSH_PC = 2'd3;
    localparam logic [4:0] DIS_WORD   = 5'b01000;

    typedef struct packed {
        logic [1:0]       op;
        logic [2:0]       id;
        logic [RPT_W-1:0] rpt;
    } cmd_t;

    cmd_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic [1:0]       state;
    logic [1:0]       state_n;
    logic [1:0]       cur_op;
    logic [2:0]       cur_id;
    logic [RPT_W-1:0] rpt_cnt;
    logic             wr_en;
    logic             pop;
    logic             fifo_empty;
    logic             exec;
    logic             last;

    assign fifo_empty = (count == '0);
    assign cmd_ready  = (count != FULL_LVL) && !flush;
    assign wr_en      = cmd_valid && cmd_ready;
    assign fifo_level = count;
    assign busy       = (state != IDLE) || !fifo_empty;
    assign exec       = (state == ISSUE) && !flush;
    assign last       = (rpt_cnt == '0);

    // Next state and head-pop decision; flush overrides everything
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (last) begin
                    if (cur_op == OP_PUSH_PC) begin
                        state_n = GAP;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            GAP: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (flush) begin
            pop     = 1'b0;
            state_n = IDLE;
        end
    end

    // Command FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= '{op: cmd_op, id: cmd_id, rpt: cmd_rpt};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state and the command currently being issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_op  <= '0;
            cur_id  <= '0;
            rpt_cnt <= '0;
        end else begin
            state <= state_n;
            if (pop) begin
                cur_op  <= mem[rd_ptr].op;
                cur_id  <= mem[rd_ptr].id;
                rpt_cnt <= mem[rd_ptr].rpt;
            end else if (exec && !last) begin
                rpt_cnt <= rpt_cnt - 1'b1;
            end
        end
    end

    // Registered bus word: execute word in ISSUE, disable word otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id           <= 3'b000;
            instr_out    <= DIS_WORD;
            cc_out       <= 1'b1;
            instr_en_out <= 1'b1;
            done         <= 1'b0;
        end else if (exec) begin
            id           <= cur_id;
            instr_out    <= {3'b010, cur_op};
            cc_out       <= 1'b0;
            instr_en_out <= 1'b0;
            done         <= last;
        end else begin
            instr_out    <= DIS_WORD;
            cc_out       <= 1'b1;
            instr_en_out <= 1'b1;
            done         <= 1'b0;
        end
    end

`ifdef ISSUE_STATS_EN
    // Saturating count of execute-word cycles; flush leaves it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
        end else if (exec && issue_cnt != 16'hFFFF) begin
            issue_cnt <= issue_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Directed table-driven bench for instr_issue_sequencer.
// Multi-cycle corner cases (FIFO fill, flush, reset, max repeat) are hand sequences.
module tb_instr_issue_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_id;
    logic [3:0] cmd_rpt;
    logic       flush;
    logic [2:0] id;
    logic [4:0] instr_out;
    logic       cc_out;
    logic       instr_en_out;
    logic       busy;
    logic       done;
    logic [2:0] fifo_level;
`ifdef ISSUE_STATS_EN
    logic [15:0] issue_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] dq[$];

    instr_issue_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_id       (cmd_id),
        .cmd_rpt      (cmd_rpt),
        .flush        (flush),
        .id           (id),
        .instr_out    (instr_out),
        .cc_out       (cc_out),
        .instr_en_out (instr_en_out),
        .busy         (busy),
        .done         (done),
        .fifo_level   (fifo_level)
`ifdef ISSUE_STATS_EN
        ,
        .issue_cnt    (issue_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [2:0] cid;
        logic [3:0] rpt;
        logic [2:0] e_id;
        logic [4:0] e_instr;
        logic       e_cc;
        logic       e_en;
        logic       e_done;
        logic       e_busy;
        logic [2:0] e_lvl;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic v, input logic [1:0] op,
                                input logic [2:0] cid, input logic [3:0] rpt,
                                input logic [2:0] eid, input logic [4:0] ein,
                                input logic ecc, input logic een,
                                input logic edn, input logic ebs,
                                input logic [2:0] elv);
        vec_t r;
        r.v = v; r.op = op; r.cid = cid; r.rpt = rpt;
        r.e_id = eid; r.e_instr = ein; r.e_cc = ecc; r.e_en = een;
        r.e_done = edn; r.e_busy = ebs; r.e_lvl = elv;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done) dq.push_back({id, instr_out});
    endtask

    task automatic drive(input logic v, input logic [1:0] op,
                         input logic [2:0] cid, input logic [3:0] rpt);
        cmd_valid = v; cmd_op = op; cmd_id = cid; cmd_rpt = rpt;
    endtask

    task automatic chk_disable(input string nm, input logic [2:0] eid);
        chk(nm, {id, instr_out, cc_out, instr_en_out, done, busy, fifo_level},
            {eid, 5'b01000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0});
    endtask

    task automatic start_long();
        drive(1, 2'd2, 3'd3, 4'd5); tick();
        drive(1, 2'd1, 3'd4, 4'd0); tick();
        drive(1, 2'd0, 3'd5, 4'd0); tick();
        drive(0, 2'd0, 3'd0, 4'd0); tick();
        chk("mid_issue_en", {29'd0, instr_en_out, id}, {29'd0, 1'b0, 3'd3});
    endtask

    initial begin
        int n;
        int cnt;
        logic [7:0] exp_q[6];

        tbl[0]  = mk(0, 0, 0, 0,  0, 5'h08, 1, 1, 0, 0, 0);
        tbl[1]  = mk(1, 1, 2, 0,  0, 5'h08, 1, 1, 0, 1, 1);
        tbl[2]  = mk(0, 0, 0, 0,  0, 5'h08, 1, 1, 0, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0,  2, 5'h09, 0, 0, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0,  2, 5'h08, 1, 1, 0, 0, 0);
        tbl[5]  = mk(1, 0, 2, 2,  2, 5'h08, 1, 1, 0, 1, 1);
        tbl[6]  = mk(1, 2, 5, 0,  2, 5'h08, 1, 1, 0, 1, 1);
        tbl[7]  = mk(1, 1, 1, 1,  2, 5'h08, 0, 0, 0, 1, 2);
        tbl[8]  = mk(0, 0, 0, 0,  2, 5'h08, 0, 0, 0, 1, 2);
        tbl[9]  = mk(0, 0, 0, 0,  2, 5'h08, 0, 0, 1, 1, 1);
        tbl[10] = mk(0, 0, 0, 0,  5, 5'h0A, 0, 0, 1, 1, 0);
        tbl[11] = mk(0, 0, 0, 0,  1, 5'h09, 0, 0, 0, 1, 0);
        tbl[12] = mk(0, 0, 0, 0,  1, 5'h09, 0, 0, 1, 0, 0);
        tbl[13] = mk(0, 0, 0, 0,  1, 5'h08, 1, 1, 0, 0, 0);
        tbl[14] = mk(1, 3, 2, 1,  1, 5'h08, 1, 1, 0, 1, 1);
        tbl[15] = mk(1, 0, 2, 0,  1, 5'h08, 1, 1, 0, 1, 1);
        tbl[16] = mk(0, 0, 0, 0,  2, 5'h0B, 0, 0, 0, 1, 1);
        tbl[17] = mk(0, 0, 0, 0,  2, 5'h0B, 0, 0, 1, 1, 1);
        tbl[18] = mk(0, 0, 0, 0,  2, 5'h08, 1, 1, 0, 1, 0);
        tbl[19] = mk(0, 0, 0, 0,  2, 5'h08, 0, 0, 1, 0, 0);
        tbl[20] = mk(0, 0, 0, 0,  2, 5'h08, 1, 1, 0, 0, 0);

        rst_n = 1'b0;
        flush = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_disable("reset_values", 3'd0);
        chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            tick();
            chk_disable($sformatf("idle_hold[%0d]", i), 3'd0);
        end

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].cid, tbl[i].rpt);
            tick();
            chk($sformatf("vec[%0d]", i),
                {id, instr_out, cc_out, instr_en_out, done, busy, fifo_level, cmd_ready},
                {tbl[i].e_id, tbl[i].e_instr, tbl[i].e_cc, tbl[i].e_en,
                 tbl[i].e_done, tbl[i].e_busy, tbl[i].e_lvl, 1'b1});
        end
        drive(0, 0, 0, 0);

        dq.delete();
        exp_q[0] = {3'd2, 5'h09};
        exp_q[1] = {3'd3, 5'h0A};
        exp_q[2] = {3'd4, 5'h08};
        exp_q[3] = {3'd5, 5'h09};
        exp_q[4] = {3'd6, 5'h0A};
        exp_q[5] = {3'd7, 5'h08};
        drive(1, 2'd1, 3'd2, 4'd7); tick();
        drive(1, 2'd2, 3'd3, 4'd0); tick();
        drive(1, 2'd0, 3'd4, 4'd0); tick();
        drive(1, 2'd1, 3'd5, 4'd0); tick();
        drive(1, 2'd2, 3'd6, 4'd0); tick();
        chk("full_level", {29'd0, fifo_level}, 32'd4);
        chk("full_ready", {31'd0, cmd_ready}, 32'd0);
        drive(1, 2'd3, 3'd1, 4'd0); tick();
        chk("full_hold_level", {29'd0, fifo_level}, 32'd4);
        chk("full_hold_ready", {31'd0, cmd_ready}, 32'd0);
        drive(0, 0, 0, 0);
        repeat (4) tick();
        chk("first_pop_level", {29'd0, fifo_level}, 32'd3);
        drive(1, 2'd0, 3'd7, 4'd0); tick();
        chk("pop_write_level", {29'd0, fifo_level}, 32'd3);
        drive(0, 0, 0, 0);
        repeat (12) tick();
        chk("fill_done_count", dq.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("fill_order[%0d]", i),
                (i < dq.size()) ? {24'd0, dq[i]} : 32'hFFFF, {24'd0, exp_q[i]});
        end
        chk_disable("fill_drained", 3'd7);

        dq.delete();
        start_long();
        flush = 1'b1;
        drive(1, 2'd3, 3'd6, 4'd0);
        #1;
        chk("flush_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        flush = 1'b0;
        drive(0, 0, 0, 0);
        chk_disable("flush_next", 3'd3);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!instr_en_out) cnt++;
        end
        chk("flush_no_exec", cnt, 32'd0);
        chk("flush_no_done", dq.size(), 32'd0);

        start_long();
        #2;
        rst_n = 1'b0;
        #1;
        chk_disable("reset_mid_issue", 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!instr_en_out) cnt++;
        end
        chk("reset_no_replay", cnt, 32'd0);
        chk("reset_no_done", dq.size(), 32'd0);

        drive(1, 2'd1, 3'd2, 4'd15); tick();
        drive(0, 0, 0, 0);
        n = 0;
        while (instr_en_out && n < 10) begin
            tick();
            n++;
        end
        cnt = 0;
        while (!instr_en_out && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("rpt_max_cycles", cnt, 32'd16);
        chk("rpt_max_done", dq.size(), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
